// File: rtl/rom_port_arbiter_if.sv
// Request/response bundle between the fetch/load front ends (master) and rom_port_arbiter (slave).
interface rom_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic              ld_req_valid;
  logic [ADDR_W-1:0] ld_req_addr;
  logic              ld_req_ready;
  logic              ld_resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;

  modport master (
    output if_req_valid, if_req_addr, ld_req_valid, ld_req_addr,
    input  if_req_ready, if_resp_valid, ld_req_ready, ld_resp_valid, resp_data, resp_err
  );

  modport slave (
    input  if_req_valid, if_req_addr, ld_req_valid, ld_req_addr,
    output if_req_ready, if_resp_valid, ld_req_ready, ld_resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing a byte-wide synchronous ROM between fetch and load, returning 32-bit LE words.
// Define ROM_ARB_PERF_EN to add saturating grant/conflict performance counters.
module rom_port_arbiter #(
  parameter int unsigned ROM_BYTES = 16384,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_rdata
`ifdef ROM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_ld_grants,
  output logic [31:0]       perf_conflict_cycles
`endif
);

  localparam int unsigned EXT_W = ADDR_W + 1;
  localparam logic [EXT_W-1:0] LAST_OK = EXT_W'(ROM_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_RESP} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_cnt;
  logic              r_owner_ld;
  logic              r_last_ld;
  logic [23:0]       r_asm;
  logic [31:0]       r_data;
  logic              r_err;
  logic              r_if_resp;
  logic              r_ld_resp;
  logic [ADDR_W-1:0] r_rom_addr;

  logic              w_pick_ld;
  logic              w_if_rdy;
  logic              w_ld_rdy;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_range;

  // Arbitration, range check and next state; readies are forced low while reset is asserted
  always_comb begin
    w_state_nxt = r_state;
    w_if_rdy    = 1'b0;
    w_ld_rdy    = 1'b0;
    w_pick_ld   = bus.ld_req_valid && (!bus.if_req_valid || !r_last_ld);
    w_addr      = w_pick_ld ? bus.ld_req_addr : bus.if_req_addr;
    w_in_range  = ({1'b0, w_addr} + EXT_W'(3)) <= LAST_OK;
    case (r_state)
      S_IDLE: begin
        w_if_rdy = rst_n && bus.if_req_valid && !w_pick_ld;
        w_ld_rdy = rst_n && w_pick_ld;
        if (w_if_rdy || w_ld_rdy) begin
          w_state_nxt = w_in_range ? S_RD : S_RESP;
        end
      end
      S_RD:    if (r_cnt == 2'd3) w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = w_if_rdy || w_ld_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Address sequencing, byte assembly and response pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      r_owner_ld <= 1'b0;
      r_last_ld  <= 1'b1;
      r_asm      <= 24'd0;
      r_data     <= 32'd0;
      r_err      <= 1'b0;
      r_if_resp  <= 1'b0;
      r_ld_resp  <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_if_resp <= 1'b0;
      r_ld_resp <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner_ld <= w_ld_rdy;
            r_last_ld  <= w_ld_rdy;
            r_cnt      <= 2'd0;
            if (w_in_range) begin
              r_rom_addr <= w_addr;
            end else begin
              r_data    <= 32'd0;
              r_err     <= 1'b1;
              r_if_resp <= w_if_rdy;
              r_ld_resp <= w_ld_rdy;
            end
          end
        end
        S_RD: begin
          // rom_rdata lags rom_addr by one cycle, so byte k arrives while r_cnt == k+1
          if (r_cnt != 2'd0) r_asm <= {rom_rdata, r_asm[23:8]};
          if (r_cnt != 2'd3) begin
            r_cnt      <= r_cnt + 2'd1;
            r_rom_addr <= r_rom_addr + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          r_data    <= {rom_rdata, r_asm};
          r_if_resp <= !r_owner_ld;
          r_ld_resp <= r_owner_ld;
        end
        default: ;
      endcase
    end
  end

  assign bus.if_req_ready  = w_if_rdy;
  assign bus.ld_req_ready  = w_ld_rdy;
  assign bus.if_resp_valid = r_if_resp;
  assign bus.ld_resp_valid = r_ld_resp;
  assign bus.resp_data     = r_data;
  assign bus.resp_err      = r_err;
  assign rom_addr          = r_rom_addr;

`ifdef ROM_ARB_PERF_EN
  logic [31:0] r_perf_if;
  logic [31:0] r_perf_ld;
  logic [31:0] r_perf_conf;
  logic        w_conflict;

  assign w_conflict = (bus.if_req_valid && !w_if_rdy) || (bus.ld_req_valid && !w_ld_rdy);

  // Saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_if   <= 32'd0;
      r_perf_ld   <= 32'd0;
      r_perf_conf <= 32'd0;
    end else begin
      if (w_if_rdy && (r_perf_if != 32'hFFFF_FFFF))     r_perf_if   <= r_perf_if + 32'd1;
      if (w_ld_rdy && (r_perf_ld != 32'hFFFF_FFFF))     r_perf_ld   <= r_perf_ld + 32'd1;
      if (w_conflict && (r_perf_conf != 32'hFFFF_FFFF)) r_perf_conf <= r_perf_conf + 32'd1;
    end
  end

  assign perf_if_grants       = r_perf_if;
  assign perf_ld_grants       = r_perf_ld;
  assign perf_conflict_cycles = r_perf_conf;
`endif

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single byte-wide, synchronous-read program ROM between two requesters: instruction fetch (if_) and data load (ld_).
- Each accepted request is sequenced as four byte reads, assembled little-endian into a 32-bit word, and returned to the granted requester.
- Sits between the core's fetch/LSU front ends and the rom instance. The arbiter is the only driver of the ROM address.

Parameters:
- ROM_BYTES, 16384, ROM depth in bytes; must match the rom instance depth.
- ADDR_W, 32, request and ROM address width.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req_valid  input  1  fetch request; held with address until accepted.
- if_req_addr  input  ADDR_W  fetch byte address.
- if_req_ready  output  1  fetch request accepted this cycle.
- if_resp_valid  output  1  one-cycle pulse; resp_data/resp_err are for fetch.
- ld_req_valid  input  1  load request; held with address until accepted.
- ld_req_addr  input  ADDR_W  load byte address.
- ld_req_ready  output  1  load request accepted this cycle.
- ld_resp_valid  output  1  one-cycle pulse; resp_data/resp_err are for load.
- resp_data  output  32  assembled word; the shared response bus.
- resp_err  output  1  qualifies the response pulse; out-of-range request.
- rom_addr  output  ADDR_W  registered byte address to the ROM.
- rom_rdata  input  8  ROM byte; valid one cycle after rom_addr is presented.

Behaviour:
- Reset values (while rst_n is low): all outputs 0, FSM in IDLE, last_grant = LD (so fetch wins the first tie).
- FSM states:
  - IDLE: accepts a request.
  - RD: issues the four byte addresses, byte counter 0..3.
  - WAIT: waits one cycle for the final byte from the ROM.
  - RESP: pulses the response.
  - Valid transitions: IDLE→RD (in range), RD→RD (cnt<3), RD→WAIT (cnt==3), WAIT→RESP, RESP→IDLE, IDLE→RESP (out of range).
- Ready generation: if_req_ready and ld_req_ready are combinational and high only in IDLE. Only the granted requester's ready may be high.
- Arbitration is round-robin:
  - A single active request wins.
  - If both request, the one not equal to last_grant wins.
  - last_grant updates on every accept.
- Accept (cycle A, valid && ready):
  - Registers base = addr and the grant owner.
  - Range check: base + 3 must be ≤ ROM_BYTES-1, computed in ADDR_W+1 bits so it cannot wrap. An address near 2^32 is therefore out of range.
- In-range request timing:
  - rom_addr = base+k during cycle A+1+k, for k = 0..3.
  - Byte k is sampled from rom_rdata in cycle A+2+k and placed in resp_data[8k+7:8k]. Byte 0 goes to bits 7:0.
  - The owner's resp_valid pulses in cycle A+6 with resp_err=0.
  - The FSM returns to IDLE, so the next accept can occur no earlier than cycle A+7. Throughput is one word per 7 cycles.
- Out-of-range request:
  - No ROM addresses are issued; rom_addr holds its previous value.
  - The owner's resp_valid pulses in cycle A+1 with resp_data=0 and resp_err=1.
- Misaligned base addresses (addr[1:0] ≠ 0) are legal: bytes base..base+3 are returned.
- Between responses:
  - resp_data holds its last value.
  - resp_err is low except during the response pulse.
  - if_resp_valid and ld_resp_valid are never high together.
- A requester dropping req_valid before it is accepted is legal; no side effects.
- A new request arriving while the FSM is busy waits; ready stays low.
- Reset asserted mid-transaction: the in-flight transaction is discarded and no response is generated. After reset is released the FSM starts in IDLE.

Optional Feature:
- Macro: ROM_ARB_PERF_EN.
- When defined, adds three 32-bit output counters, cleared by rst_n and saturating at 0xFFFFFFFF:
  - perf_if_grants: increments on each fetch accept.
  - perf_ld_grants: increments on each load accept.
  - perf_conflict_cycles: increments on each cycle where a request is valid but not ready.
- When undefined, these ports and their logic are absent. Request/response behaviour is identical in both builds.

Test Plan:
- Single fetch: ROM bytes 0x00..0x03 = 13 05 00 00; if_req addr 0x0 → rom_addr 0,1,2,3 in cycles A+1..A+4; if_resp_valid in A+6 with resp_data=0x00000513, resp_err=0.
- Simultaneous if_ and ld_ requests from reset, addresses 0x10 and 0x20 → fetch granted first; load granted at A+7. Responses arrive in order fetch then load, each with the correct word; no overlapping resp_valid.
- Continuous dual requests for 10 grants → grants strictly alternate if/ld/if/ld.
- ld_req addr ROM_BYTES-2 → ld_resp_valid at A+1, resp_err=1, resp_data=0, no change on rom_addr. Repeat with addr 0xFFFFFFFE: same result.
- Misaligned fetch addr 0x1 over bytes 0xAA,0xBB,0xCC,0xDD,0xEE at 0..4 → resp_data=0xEEDDCCBB.
- rst_n pulsed low in cycle A+3 of a fetch → no if_resp_valid; outputs 0 during reset. A fetch after reset is accepted in the first cycle and completes normally.
